// File: rtl/div32_seq_pkg.sv
// Shared ALU definitions for div32_seq: FSM state encodings, the iteration count
// and the divide-by-zero quotient constant, plus a two's-complement helper.
package div32_seq_pkg;

  localparam int          WIDTH         = 32;
  localparam int          ITERATIONS    = 32;
  localparam logic [4:0]  CNT_INIT      = 5'(ITERATIONS - 1);
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_ZERO = 2'd3
  } state_t;

  // Inverse-plus-one negation; kept out of the adder so only one adder32 exists.
  function automatic logic [31:0] negate32(input logic [31:0] value);
    return ~value + 32'd1;
  endfunction

endpackage

// File: rtl/adder32.sv
// 32-bit adder/subtractor; with sub=1 it forms A - B and CARRY_OUT=1 means no borrow.
module adder32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        sub,
  output logic [31:0] SUM,
  output logic        CARRY_OUT
);

  logic [31:0] b_eff;
  logic [32:0] total;

  assign b_eff = sub ? ~B : B;
  assign total = {1'b0, A} + {1'b0, b_eff} + {32'd0, sub};
  assign {CARRY_OUT, SUM} = total;

endmodule

// File: rtl/div32_seq.sv
// Sequential 32-bit restoring divider with fixed latency (34 edges, 2 for B==0).
// Signed operation is compiled in only when DIV_SIGNED_EN is defined.
module div32_seq
  import div32_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        signed_op,
  output logic        busy,
  output logic        done,
  output logic [31:0] QUOT,
  output logic [31:0] REM,
  output logic        DIV_ZERO
);

  state_t      state_reg, state_next;
  logic [31:0] rem_reg, rem_next;
  logic [31:0] quo_reg, quo_next;
  logic [31:0] div_reg, div_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [31:0] quot_out_reg, quot_out_next;
  logic [31:0] rem_out_reg, rem_out_next;
  logic        dz_reg, dz_next;
  logic        done_reg, done_next;

  logic [32:0] shifted;
  logic [31:0] trial_sum;
  logic        trial_carry;
  logic        take;
  logic [31:0] op_a;
  logic [31:0] op_b;

  assign shifted = {rem_reg, quo_reg[31]};

  adder32 u_adder (
    .A         (shifted[31:0]),
    .B         (div_reg),
    .sub       (1'b1),
    .SUM       (trial_sum),
    .CARRY_OUT (trial_carry)
  );

  assign take = trial_carry | shifted[32];

`ifdef DIV_SIGNED_EN
  logic neg_q_reg, neg_q_next;
  logic neg_r_reg, neg_r_next;

  assign op_a = (signed_op && A[31]) ? negate32(A) : A;
  assign op_b = (signed_op && B[31]) ? negate32(B) : B;
`else
  logic unused_signed_op;

  assign unused_signed_op = signed_op;
  assign op_a = A;
  assign op_b = B;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_reg      <= '0;
      quo_reg      <= '0;
      div_reg      <= '0;
      cnt_reg      <= '0;
      quot_out_reg <= '0;
      rem_out_reg  <= '0;
      dz_reg       <= 1'b0;
      done_reg     <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
`endif
    end else begin
      rem_reg      <= rem_next;
      quo_reg      <= quo_next;
      div_reg      <= div_next;
      cnt_reg      <= cnt_next;
      quot_out_reg <= quot_out_next;
      rem_out_reg  <= rem_out_next;
      dz_reg       <= dz_next;
      done_reg     <= done_next;
`ifdef DIV_SIGNED_EN
      neg_q_reg    <= neg_q_next;
      neg_r_reg    <= neg_r_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    rem_next      = rem_reg;
    quo_next      = quo_reg;
    div_next      = div_reg;
    cnt_next      = cnt_reg;
    quot_out_next = quot_out_reg;
    rem_out_next  = rem_out_reg;
    dz_next       = dz_reg;
    done_next     = 1'b0;
`ifdef DIV_SIGNED_EN
    neg_q_next    = neg_q_reg;
    neg_r_next    = neg_r_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          rem_next = '0;
          cnt_next = CNT_INIT;
          div_next = op_b;
`ifdef DIV_SIGNED_EN
          neg_r_next = signed_op & A[31];
          neg_q_next = signed_op & (A[31] ^ B[31]);
`endif
          if (B == 32'd0) begin
            // The ZERO path reports the raw dividend, so keep it unmodified.
            quo_next   = A;
            state_next = ST_ZERO;
          end else begin
            quo_next   = op_a;
            state_next = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        rem_next = take ? trial_sum : shifted[31:0];
        quo_next = {quo_reg[30:0], take};
        cnt_next = cnt_reg - 5'd1;
        if (cnt_reg == 5'd0) begin
          cnt_next   = 5'd0;
          state_next = ST_FIX;
        end
      end

      ST_FIX: begin
`ifdef DIV_SIGNED_EN
        quot_out_next = neg_q_reg ? negate32(quo_reg) : quo_reg;
        rem_out_next  = neg_r_reg ? negate32(rem_reg) : rem_reg;
`else
        quot_out_next = quo_reg;
        rem_out_next  = rem_reg;
`endif
        dz_next    = 1'b0;
        done_next  = 1'b1;
        state_next = ST_IDLE;
      end

      ST_ZERO: begin
        quot_out_next = DIV_ZERO_QUOT;
        rem_out_next  = quo_reg;
        dz_next       = 1'b1;
        done_next     = 1'b1;
        state_next    = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign busy     = (state_reg != ST_IDLE);
  assign done     = done_reg;
  assign QUOT     = quot_out_reg;
  assign REM      = rem_out_reg;
  assign DIV_ZERO = dz_reg;

endmodule
